toeplitz_serializer: RTL
========================

TOEPLITZ_SERIALIZER -- requirements
Module: toeplitz_serializer

Interface
REQ-001 Parameter L, default 128: extracted block width in bits; SHALL equal the extractor's L.
REQ-002 Parameter W, default 32: output word width; L SHALL be an integer multiple of W (elaboration-time check).
REQ-003 Parameter DEPTH, default 2: block buffer depth in blocks; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 q  input  L  extracted block from the upstream extractor.
REQ-007 qstrobe  input  1  one-cycle pulse: q holds a new block this cycle.
REQ-008 dout  output  W  current output word.
REQ-009 dvalid  output  1  dout holds a valid word.
REQ-010 dready  input  1  downstream accepts dout.
REQ-011 overflow  output  1  sticky: at least one block has been dropped since reset.
REQ-012 drop_count  output  16  number of dropped blocks, saturating at 16'hFFFF.
REQ-013 level  output  $clog2(DEPTH)+1  number of blocks held, including the block being serialized.

Function
REQ-014 A word transfer SHALL occur in any cycle with dvalid && dready.
REQ-015 Blocks SHALL be stored in a FIFO of DEPTH entries and emitted in arrival order.
REQ-016 Each block SHALL be emitted as L/W words, LSB first: word k = block[k*W +: W], for k = 0 .. L/W-1.
REQ-017 dvalid SHALL be 1 exactly when level > 0.
REQ-018 dout SHALL equal the word of the head block selected by the registered word index; while dvalid && !dready, dout SHALL remain stable.
REQ-019 Latency: a qstrobe at edge t into an empty buffer SHALL give dvalid=1 and dout=q[W-1:0] in the cycle after edge t.
REQ-020 On a transfer of word index L/W-1: the head block SHALL be popped, the word index SHALL wrap to 0, and level SHALL decrement, unless a push occurs in the same cycle.
REQ-021 On other transfers, the word index SHALL increment and level SHALL be unchanged.
REQ-022 When qstrobe=1 and level < DEPTH, q SHALL be pushed and level SHALL increment, unless a pop occurs in the same cycle.
REQ-023 Full and simultaneous pop: when qstrobe=1, level == DEPTH and the last word of the head is transferred in the same cycle, the push SHALL be accepted, level SHALL stay DEPTH, and no drop is counted.
REQ-024 Full with no pop: when qstrobe=1, level == DEPTH and no pop occurs, the block SHALL be discarded, overflow SHALL be set, and drop_count SHALL increment (saturating). Buffer contents SHALL be unaffected.
REQ-025 Push and pop in the same cycle at level 1: the new block SHALL become the head, and its word 0 SHALL be presented in the next cycle without a dvalid gap.
REQ-026 dready while dvalid=0 SHALL have no effect.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 While reset=1 at a clock edge: level=0, dvalid=0, word index=0, read/write pointers=0, overflow=0, drop_count=0, dout=0.
REQ-029 Reset mid-block SHALL discard all buffered and partially emitted blocks; no residual word SHALL appear after reset.
REQ-030 qstrobe asserted during reset SHALL be ignored.
REQ-031 Block storage SHALL NOT require reset.

Structure
REQ-032 Package toeplitz_pkg SHALL hold the shared defaults BS, N, L and W, and the drop-counter width (16), so that the extractor and serializer agree on these values.
REQ-033 One sub-module, toeplitz_blkfifo, SHALL implement the DEPTH x L synchronous FIFO with push, pop, full, empty and level.
REQ-034 The word select, drop counter and overflow logic SHALL reside in toeplitz_serializer.

Verification
REQ-035 Single block, dready=1: after reset, one qstrobe with q=128'h0123456789ABCDEF_FEDCBA9876543210 -> dout sequence 76543210, FEDCBA98, 89ABCDEF, 01234567 on 4 consecutive cycles, starting 1 cycle after qstrobe; then dvalid=0.
REQ-036 Backpressure: same block, dready toggled 1,0,0,1,... -> dout holds each word while dready=0; all 4 words are delivered in order with no loss or duplication.
REQ-037 Overflow: dready=0, three qstrobes with q=1, 2, 3 -> level=2, overflow=1, drop_count=1; after raising dready, the words are those of blocks 1 then 2 only.
REQ-038 Simultaneous push/pop at full: level=2, qstrobe coincides with the last-word transfer -> level stays 2, drop_count unchanged, new block emitted after the remaining one.
REQ-039 Reset mid-block: assert reset after word 1 of block A is transferred -> dvalid=0 the next cycle; a later block B is emitted from its word 0; drop_count=0.
REQ-040 Streaming with the extractor (N=256): 1000 blocks with dready=1 -> no drops; output equals the reference-model concatenation of q values.

Source files
------------

// File: rtl/toeplitz_pkg.sv
// Shared constants for the Toeplitz extractor and its output serializer.
// Both sides read them from here so their block and word widths always agree.
package toeplitz_pkg;

    localparam int BS     = 8;     // raw sample width fed to the extractor
    localparam int N      = 256;   // raw input bits consumed per extraction
    localparam int L      = 128;   // extracted block width
    localparam int W      = 32;    // serializer output word width
    localparam int DROP_W = 16;    // width of the saturating drop counter

    function automatic int words_per_block(input int l, input int w);
        return l / w;
    endfunction

endpackage

// File: rtl/toeplitz_blkfifo.sv
// DEPTH x L synchronous block FIFO with a combinational head view.
// The caller never pushes into a full FIFO unless it pops in the same cycle.
module toeplitz_blkfifo #(
    parameter int L     = toeplitz_pkg::L,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [L-1:0]             din,
    input  logic                     pop,
    output logic [L-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    import toeplitz_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [L-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] count;

    // Storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so plain pointer overflow gives the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == LVL_W'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/toeplitz_serializer.sv
// Buffers extracted L-bit blocks and streams them out LSB-first as W-bit words
// with valid/ready handshaking; blocks arriving into a full buffer are dropped and counted.
module toeplitz_serializer #(
    parameter int L     = toeplitz_pkg::L,
    parameter int W     = toeplitz_pkg::W,
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [L-1:0]                      q,
    input  logic                              qstrobe,
    output logic [W-1:0]                      dout,
    output logic                              dvalid,
    input  logic                              dready,
    output logic                              overflow,
    output logic [toeplitz_pkg::DROP_W-1:0]   drop_count,
    output logic [$clog2(DEPTH):0]            level
);
    import toeplitz_pkg::*;

    localparam int WORDS = words_per_block(L, W);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    if ((L % W) != 0) begin : g_bad_width
        $error("toeplitz_serializer: L must be an integer multiple of W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("toeplitz_serializer: DEPTH must be a power of two and at least 2");
    end

    logic [L-1:0]     head;
    logic             full;
    logic             empty;
    logic [IDX_W-1:0] word_idx;
    logic [W-1:0]     words [WORDS];
    logic             xfer;
    logic             last_word;
    logic             pop;
    logic             push;
    logic             drop;

    assign dvalid    = !empty;
    assign xfer      = dvalid && dready;
    assign last_word = (word_idx == IDX_W'(WORDS - 1));
    assign pop       = xfer && last_word;
    // A pop frees a slot in the same cycle, so a full buffer still accepts then.
    assign push      = qstrobe && (!full || pop);
    assign drop      = qstrobe && full && !pop;

    toeplitz_blkfifo #(
        .L     (L),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (q),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    for (genvar k = 0; k < WORDS; k++) begin : g_words
        assign words[k] = head[k*W +: W];
    end

    assign dout = dvalid ? words[word_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx <= '0;
        end else if (xfer) begin
            word_idx <= last_word ? '0 : word_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule
